// File: rtl/port_rd_frontend.sv
// Port read front end: per-queue packet counters plus a request FSM that
// consults the dispatcher's queue choice and tracks one packet read at a time.
module port_rd_frontend #(
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_done,
  input  logic [2:0] wr_queue,
  input  logic [2:0] prior,
  input  logic       rd_ready,
  input  logic       rd_ack,
  input  logic       rd_valid,
  input  logic       rd_last,
  output logic [7:0] queue_available,
  output logic       next,
  output logic       rd_req,
  output logic [2:0] rd_queue,
  output logic       busy,
  output logic       cnt_ovf
);

  typedef enum logic [1:0] {StIdle, StSettle, StReq, StXfer} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [2:0]       rd_queue_q, rd_queue_d;
  logic             next_q, next_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       inc_vec, dec_vec;

  assign inc_vec = wr_done ? (8'b1 << wr_queue) : 8'b0;
  assign dec_vec = ((state_q == StReq) && rd_ack) ? (8'b1 << rd_queue_q) : 8'b0;

  // Simultaneous increment and decrement on one queue cancel out, so a full
  // counter being drained in the same cycle is not an overflow.
  always_comb begin
    ovf_d = ovf_q;
    for (int q = 0; q < 8; q++) begin
      cnt_d[q] = cnt_q[q];
      if (inc_vec[q] && !dec_vec[q]) begin
        if (cnt_q[q] == CntMax) ovf_d = 1'b1;
        else                    cnt_d[q] = cnt_q[q] + CNT_W'(1);
      end else if (dec_vec[q] && !inc_vec[q] && (cnt_q[q] != '0)) begin
        cnt_d[q] = cnt_q[q] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    queue_available = 8'h00;
    for (int q = 0; q < 8; q++) begin
      queue_available[q] = |cnt_q[q];
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_queue_d = rd_queue_q;
    next_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if ((queue_available != 8'h00) && rd_ready) state_d = StSettle;
      end
      // prior is registered in the dispatcher, so it is only trusted one cycle on.
      StSettle: begin
        if (cnt_q[prior] != '0) begin
          rd_queue_d = prior;
          state_d    = StReq;
        end else begin
          state_d = StIdle;
        end
      end
      StReq: begin
        if (rd_ack) state_d = StXfer;
      end
      StXfer: begin
        if (rd_valid && rd_last) begin
          next_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= StIdle;
      rd_queue_q <= 3'd0;
      next_q     <= 1'b0;
      ovf_q      <= 1'b0;
      for (int q = 0; q < 8; q++) cnt_q[q] <= '0;
    end else begin
      state_q    <= state_d;
      rd_queue_q <= rd_queue_d;
      next_q     <= next_d;
      ovf_q      <= ovf_d;
      for (int q = 0; q < 8; q++) cnt_q[q] <= cnt_d[q];
    end
  end

  assign rd_req   = (state_q == StReq);
  assign busy     = (state_q != StIdle);
  assign next     = next_q;
  assign rd_queue = rd_queue_q;
  assign cnt_ovf  = ovf_q;

endmodule

// File: tb/tb_port_rd_frontend.sv
// Directed bench for port_rd_frontend; inputs driven and outputs sampled 1ns after clk rises.
module tb_port_rd_frontend;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_done;
  logic [2:0] wr_queue;
  logic [2:0] prior;
  logic       rd_ready;
  logic       rd_ack;
  logic       rd_valid;
  logic       rd_last;
  logic [7:0] queue_available;
  logic       next;
  logic       rd_req;
  logic [2:0] rd_queue;
  logic       busy;
  logic       cnt_ovf;

  int n_checks = 0;
  int n_fails  = 0;

  port_rd_frontend #(.CNT_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_done         (wr_done),
    .wr_queue        (wr_queue),
    .prior           (prior),
    .rd_ready        (rd_ready),
    .rd_ack          (rd_ack),
    .rd_valid        (rd_valid),
    .rd_last         (rd_last),
    .queue_available (queue_available),
    .next            (next),
    .rd_req          (rd_req),
    .rd_queue        (rd_queue),
    .busy            (busy),
    .cnt_ovf         (cnt_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b1; wr_done = 1'b0; wr_queue = 3'd0; prior = 3'd3;
    rd_ready = 1'b0; rd_ack = 1'b0; rd_valid = 1'b0; rd_last = 1'b0;
    #2;
    check("rst_avail", queue_available, 8'h00);
    check("rst_next", next, 1'b0);
    check("rst_req", rd_req, 1'b0);
    check("rst_queue", rd_queue, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", cnt_ovf, 1'b0);
    tick(); tick();
    rst_n = 1'b0;
    tick();

    // Two packets into queue 3 while downstream is not ready.
    wr_done = 1'b1; wr_queue = 3'd3;
    tick(); tick();
    wr_done = 1'b0;
    check("avail_q3", queue_available, 8'h08);
    tick(); tick(); tick();
    check("noready_busy", busy, 1'b0);
    check("noready_req", rd_req, 1'b0);

    rd_ready = 1'b1;
    tick();
    check("settle_busy", busy, 1'b1);
    check("settle_req", rd_req, 1'b0);
    tick();
    check("req_lat2", rd_req, 1'b1);
    check("req_queue", rd_queue, 3'd3);

    // Hold off ack; rd_ready drops and stray beats arrive, request must hold.
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_valid = (i == 2); rd_last = (i == 2);
      tick();
      check("req_hold", rd_req, 1'b1);
      check("req_hold_q", rd_queue, 3'd3);
      check("req_no_next", next, 1'b0);
    end
    rd_valid = 1'b0; rd_last = 1'b0;

    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("xfer_req_low", rd_req, 1'b0);
    check("xfer_busy", busy, 1'b1);
    check("xfer_avail", queue_available, 8'h08);
    rd_last = 1'b1;
    tick();
    check("last_no_valid", next, 1'b0);
    check("last_no_valid_busy", busy, 1'b1);
    rd_valid = 1'b1; rd_last = 1'b0;
    tick();
    check("beat_next", next, 1'b0);
    rd_last = 1'b1;
    tick();
    rd_valid = 1'b0; rd_last = 1'b0;
    check("done_next", next, 1'b1);
    check("done_idle", busy, 1'b0);
    tick();
    check("next_pulse_end", next, 1'b0);

    // Second packet of queue 3 drains it.
    rd_ready = 1'b1;
    tick(); tick();
    check("q3b_req", rd_req, 1'b1);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("q3_empty", queue_available, 8'h00);
    rd_valid = 1'b1; rd_last = 1'b1;
    tick();
    rd_valid = 1'b0; rd_last = 1'b0;
    check("q3b_next", next, 1'b1);
    tick();
    check("empty_idle", busy, 1'b0);

    // Queue 5: write and dequeue collide in one cycle.
    prior = 3'd5; wr_done = 1'b1; wr_queue = 3'd5;
    tick();
    wr_done = 1'b0;
    tick();
    check("q5_settle", busy, 1'b1);
    tick();
    check("q5_req", rd_req, 1'b1);
    check("q5_queue", rd_queue, 3'd5);
    rd_ack = 1'b1; wr_done = 1'b1;
    tick();
    rd_ack = 1'b0; wr_done = 1'b0;
    check("collide_avail", queue_available, 8'h20);
    check("collide_ovf", cnt_ovf, 1'b0);
    rd_valid = 1'b1; rd_last = 1'b1;
    tick();
    rd_valid = 1'b0; rd_last = 1'b0;
    check("q5_next", next, 1'b1);
    check("q5_next_noreq", rd_req, 1'b0);
    check("q5_next_idle", busy, 1'b0);
    tick();
    check("after_next_settle", busy, 1'b1);
    check("after_next_noreq", rd_req, 1'b0);
    tick();
    check("q5_req2", rd_req, 1'b1);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("q5_drained", queue_available, 8'h00);
    rd_valid = 1'b1; rd_last = 1'b1;
    tick();
    rd_valid = 1'b0; rd_last = 1'b0; rd_ready = 1'b0;
    tick();

    // Dispatcher points at an empty queue: SETTLE falls back to IDLE.
    prior = 3'd6; wr_done = 1'b1; wr_queue = 3'd2;
    tick(); tick();
    wr_done = 1'b0;
    check("q2_avail", queue_available, 8'h04);
    rd_ready = 1'b1;
    tick();
    check("q6_settle", busy, 1'b1);
    tick();
    check("q6_back_idle", busy, 1'b0);
    check("q6_noreq", rd_req, 1'b0);
    prior = 3'd2;
    tick(); tick();
    check("q2_req", rd_req, 1'b1);
    check("q2_queue", rd_queue, 3'd2);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0; rd_ready = 1'b0;
    check("q2_xfer_avail", queue_available, 8'h04);

    // Reset mid-transfer with the last beat presented.
    rd_valid = 1'b1; rd_last = 1'b1;
    #1 rst_n = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_next", next, 1'b0);
    check("mid_rst_req", rd_req, 1'b0);
    check("mid_rst_queue", rd_queue, 3'd0);
    check("mid_rst_avail", queue_available, 8'h00);
    tick();
    check("mid_rst_next2", next, 1'b0);
    rd_valid = 1'b0; rd_last = 1'b0; rst_n = 1'b0;
    tick();
    check("post_rst_next", next, 1'b0);
    check("post_rst_avail", queue_available, 8'h00);

    // Saturate queue 0 then drain it completely.
    wr_done = 1'b1; wr_queue = 3'd0;
    repeat (255) tick();
    check("fill_ovf", cnt_ovf, 1'b0);
    check("fill_avail", queue_available, 8'h01);
    tick();
    wr_done = 1'b0;
    check("sat_ovf", cnt_ovf, 1'b1);
    prior = 3'd0; rd_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      tick(); tick();
      check("drain_req", rd_req, 1'b1);
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0; rd_valid = 1'b1; rd_last = 1'b1;
      tick();
      rd_valid = 1'b0; rd_last = 1'b0;
    end
    rd_ready = 1'b0;
    tick();
    check("drained_avail", queue_available, 8'h00);
    check("drained_ovf", cnt_ovf, 1'b1);
    check("drained_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/port_rd_frontend.md
PORT_RD_FRONTEND -- requirements
Module: port_rd_frontend

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of each per-queue packet counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-high (asserted = 1) despite the suffix.
REQ-004 SHALL have port wr_done  input  1  one packet fully written into queue wr_queue this cycle.
REQ-005 SHALL have port wr_queue  input  3  target queue of wr_done.
REQ-006 SHALL have port prior  input  3  registered queue choice from the port read dispatcher.
REQ-007 SHALL have port rd_ready  input  1  downstream able to start a packet read.
REQ-008 SHALL have port rd_ack  input  1  read request accepted by the memory side.
REQ-009 SHALL have port rd_valid  input  1  read data beat valid.
REQ-010 SHALL have port rd_last  input  1  final beat of the packet, qualified by rd_valid.
REQ-011 SHALL have port queue_available  output  8  bit q = 1 iff counter q is non-zero; combinational from counters.
REQ-012 SHALL have port next  output  1  one-cycle pulse to the dispatcher when a packet read completes.
REQ-013 SHALL have port rd_req  output  1  read request, held until rd_ack.
REQ-014 SHALL have port rd_queue  output  3  queue being requested/read.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port cnt_ovf  output  1  sticky flag, wr_done lost to a saturated counter.

Function
REQ-017 SHALL keep eight CNT_W-bit packet counters cnt[0..7].
REQ-018 SHALL increment cnt[wr_queue] on wr_done unless it equals 2^CNT_W-1, in which case it holds and sets cnt_ovf.
REQ-019 SHALL decrement cnt[rd_queue] in the cycle rd_req and rd_ack are both high.
REQ-020 SHALL leave the counter unchanged when increment and decrement hit the same queue in one cycle (net zero, no overflow flagged).
REQ-021 SHALL implement FSM states IDLE, SETTLE, REQ, XFER.
REQ-022 IDLE: if queue_available != 0 and rd_ready -> SETTLE; else stay.
REQ-023 SETTLE: one cycle so that prior reflects current availability; if cnt[prior] != 0, latch rd_queue <= prior and go to REQ; else return to IDLE.
REQ-024 REQ: rd_req = 1; on rd_ack -> XFER; rd_queue stable throughout.
REQ-025 XFER: on rd_valid and rd_last, pulse next for exactly one cycle and go to IDLE; rd_last without rd_valid is ignored.
REQ-026 SHALL ignore rd_ack outside REQ and rd_valid/rd_last outside XFER.
REQ-027 Latency: IDLE-condition true in cycle N -> rd_req high in cycle N+2; rd_last beat in cycle M -> next high in cycle M+1 and state IDLE in M+1.
REQ-028 SHALL not de-assert rd_req once raised until rd_ack, regardless of rd_ready.
REQ-029 SHALL start no new request while next is high (IDLE entered that cycle; earliest SETTLE is next cycle).

Reset
REQ-030 On rst_n = 1, immediately: all counters 0, state IDLE, queue_available 8'h00, next 0, rd_req 0, rd_queue 0, busy 0, cnt_ovf 0.
REQ-031 Reset asserted mid-REQ or mid-XFER SHALL abort the read without a next pulse; the dequeued packet's count is not restored.
REQ-032 Only reset SHALL clear cnt_ovf.

Verification
REQ-033 Reset, then wr_done to queue 3 twice -> queue_available = 8'h08, cnt[3] = 2; rd_ready=1 -> rd_req high 2 cycles after availability, rd_queue = 3.
REQ-034 rd_ack held low 5 cycles -> rd_req stays high, rd_queue = 3; rd_ack -> cnt[3] = 1; rd_valid beats then rd_valid+rd_last -> next single pulse, state IDLE.
REQ-035 wr_done to queue 5 in the same cycle as rd_ack on queue 5 with cnt[5] = 1 -> cnt[5] stays 1, queue_available bit 5 stays 1.
REQ-036 Fill queue 0 to 255 (CNT_W=8), one more wr_done -> cnt[0] = 255, cnt_ovf = 1 and remains 1 after the queue drains.
REQ-037 Assert rst_n during XFER -> outputs at reset values that cycle, no next pulse, queue_available = 8'h00.
REQ-038 rd_ready = 0 with queues non-empty -> FSM stays IDLE, rd_req 0; rd_ready rises -> request two cycles later.
